aes_inv_round_ctrl: RTL and testbench

//  Iterative AES inverse-cipher controller: sequences one shared round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMix) over NR+1 key steps.

---
 rtl/aes_inv_round_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_ctrl.sv
// rtl/aes_inv_round_ctrl.sv - iterative AES inverse-cipher round controller with shared round datapath
// Optional abort input is enabled by defining AES_INV_CTRL_ABORT_EN.

module aes_inv_shift_rows (
  input  logic [0:127] state_i,
  output logic [0:127] state_o
);
  // Column-major state: byte index = row + 4*col; row r rotates right by r columns.
  always_comb begin
    state_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        state_o[8*(r+4*c) +: 8] = state_i[8*(r+4*((c-r+4)%4)) +: 8];
      end
    end
  end
endmodule

module aes_inv_sub_bytes (
  input  logic [0:127] state_i,
  output logic [0:127] state_o
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse computed as a^254, which conveniently maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  always_comb begin
    state_o = '0;
    for (int i = 0; i < 16; i++) begin
      state_o[8*i +: 8] = inv_sbox(state_i[8*i +: 8]);
    end
  end
endmodule

module aes_inv_mix_columns (
  input  logic [0:127] state_i,
  output logic [0:127] state_o
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {9a, 11a, 13a, 14a} built from shared doublings.
  function automatic logic [31:0] mul_set(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
  endfunction

  always_comb begin
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] m2;
    logic [31:0] m3;
    state_o = '0;
    for (int c = 0; c < 4; c++) begin
      m0 = mul_set(state_i[32*c    +: 8]);
      m1 = mul_set(state_i[32*c+8  +: 8]);
      m2 = mul_set(state_i[32*c+16 +: 8]);
      m3 = mul_set(state_i[32*c+24 +: 8]);
      state_o[32*c    +: 8] = m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24];
      state_o[32*c+8  +: 8] = m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8];
      state_o[32*c+16 +: 8] = m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16];
      state_o[32*c+24 +: 8] = m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0];
    end
  end
endmodule

module aes_inv_round_ctrl #(
  parameter int NR     = 10,
  parameter int KEY_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef AES_INV_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:127]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:127]      out_data,
  output logic              key_rd_en,
  output logic [KEY_AW-1:0] key_addr,
  input  logic [0:127]      key_data,
  output logic              busy
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    KADD  = 3'd2,
    ROUND = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [KEY_AW-1:0] ADDR_NR   = KEY_AW'(NR);
  localparam logic [KEY_AW-1:0] ADDR_NR1  = KEY_AW'(NR - 1);
  localparam logic [KEY_AW-1:0] ADDR_NR2  = KEY_AW'(NR - 2);
  localparam logic [KEY_AW-1:0] RND_LAST  = KEY_AW'(1);
  localparam logic [KEY_AW-1:0] ADDR_ZERO = '0;

  state_t              state_q, state_d;
  logic [0:127]        st_q, st_d;
  logic [KEY_AW-1:0]   rnd_q, rnd_d;
  logic [KEY_AW-1:0]   key_addr_q, key_addr_d;
  logic                key_rd_en_q, key_rd_en_d;
  logic                out_valid_q, out_valid_d;

  logic [0:127]        sr;
  logic [0:127]        sb;
  logic [0:127]        ark;
  logic [0:127]        mx;

  aes_inv_shift_rows  u_isr (.state_i(st_q), .state_o(sr));
  aes_inv_sub_bytes   u_isb (.state_i(sr),   .state_o(sb));
  assign ark = sb ^ key_data;
  aes_inv_mix_columns u_imc (.state_i(ark),  .state_o(mx));

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rnd_d       = rnd_q;
    key_addr_d  = key_addr_q;
    key_rd_en_d = key_rd_en_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d        = in_data;
          key_addr_d  = ADDR_NR;
          key_rd_en_d = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        key_addr_d = ADDR_NR1;
        state_d    = KADD;
      end
      KADD: begin
        st_d       = st_q ^ key_data;
        key_addr_d = ADDR_NR2;
        rnd_d      = ADDR_NR1;
        state_d    = ROUND;
      end
      ROUND: begin
        st_d       = mx;
        key_addr_d = (key_addr_q == ADDR_ZERO) ? ADDR_ZERO : key_addr_q - 1'b1;
        // Address 0 goes out in the last ROUND cycle, so the strobe ends here.
        if (rnd_q == RND_LAST) begin
          key_rd_en_d = 1'b0;
          state_d     = FINAL;
        end else begin
          rnd_d = rnd_q - 1'b1;
        end
      end
      FINAL: begin
        st_d        = ark;
        key_rd_en_d = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef AES_INV_CTRL_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      st_d        = '0;
      key_addr_d  = ADDR_ZERO;
      key_rd_en_d = 1'b0;
      out_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      st_q        <= '0;
      rnd_q       <= '0;
      key_addr_q  <= '0;
      key_rd_en_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rnd_q       <= rnd_d;
      key_addr_q  <= key_addr_d;
      key_rd_en_q <= key_rd_en_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = (state_q == DONE) ? st_q : '0;
  assign key_rd_en = key_rd_en_q;
  assign key_addr  = key_addr_q;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb/tb_aes_inv_round_ctrl.sv - scoreboard bench for aes_inv_round_ctrl (AES-128 and AES-256 instances)
// Instance 0 runs NR=10, instance 1 runs NR=14; each has a synchronous key store model.

module tb_aes_inv_round_ctrl;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [1:0]          iv;
  logic [1:0]          ordy;
  logic [1:0][127:0]   idata;
  logic [1:0][127:0]   kd;
  wire  [1:0]          ir;
  wire  [1:0]          ov;
  wire  [1:0]          kre;
  wire  [1:0]          bz;
  wire  [1:0][127:0]   od;
  wire  [1:0][3:0]     ka;
`ifdef AES_INV_CTRL_ABORT_EN
  logic                abort;
`endif

  logic [127:0] keys [0:1][0:15];
  logic [127:0] q0[$];
  logic [127:0] q1[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  aes_inv_round_ctrl #(.NR(10), .KEY_AW(4)) u_dut128 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .key_rd_en(kre[0]), .key_addr(ka[0]), .key_data(kd[0]), .busy(bz[0])
  );

  aes_inv_round_ctrl #(.NR(14), .KEY_AW(4)) u_dut256 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_INV_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .key_rd_en(kre[1]), .key_addr(ka[1]), .key_data(kd[1]), .busy(bz[1])
  );

  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (kre[g]) kd[g] <= keys[g][ka[g]];
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Forward S-box for key expansion, inverse found by exhaustive search.
  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] a);
    logic [7:0] v = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (tb_mul(a, 8'(y)) == 8'h01) v = 8'(y);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] tb_subw(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  task automatic expand(input int g, input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = tb_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = tb_subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) keys[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Monitor: scoreboard pops, latency, key-port order, hold-while-stalled.
  int           acc_cyc [2];
  int           exp_addr [2];
  int           rd_cnt [2];
  logic [1:0]   ov_prev = '0;
  logic [1:0]   ordy_prev = '1;
  logic [127:0] od_prev [2];

  always @(negedge clk) begin
    int nr;
    logic [127:0] e;
    for (int g = 0; g < 2; g++) begin
      nr = (g == 0) ? 10 : 14;
      if (iv[g] && ir[g]) begin
        acc_cyc[g]  = cyc;
        exp_addr[g] = nr;
        rd_cnt[g]   = 0;
      end
      if (kre[g]) begin
        check("key_addr_order", 128'(ka[g]), 128'(exp_addr[g]));
        exp_addr[g]--;
        rd_cnt[g]++;
      end
      if (ov[g] && !ov_prev[g]) begin
        check("latency", 128'(cyc - acc_cyc[g]), 128'(nr + 3));
        check("key_rd_cycles", 128'(rd_cnt[g]), 128'(nr + 1));
      end
      if (ov_prev[g] && !ordy_prev[g]) begin
        check("hold_valid", 128'(ov[g]), 128'(1));
        check("hold_data", od[g], od_prev[g]);
        check("hold_in_ready", 128'(ir[g]), 128'(0));
      end
      if (ov[g] && ordy[g]) begin
        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %h expected none", od[g]);
        end else begin
          if (g == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check("out_data", od[g], e);
        end
      end
      ov_prev[g]   = ov[g];
      ordy_prev[g] = ordy[g];
      od_prev[g]   = od[g];
    end
  end

  task automatic send(input int g, input logic [127:0] ct, input logic [127:0] pt);
    int n = 0;
    while (!ir[g] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", 128'(ir[g]), 128'(1));
    iv[g]    = 1'b1;
    idata[g] = ct;
    if (g == 0) q0.push_back(pt);
    else        q1.push_back(pt);
    @(posedge clk); #1;
    iv[g]    = 1'b0;
    idata[g] = '0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (bz[g] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 128'(bz[g]), 128'(0));
  endtask

  task automatic check_reset(input int g);
    check("rst_in_ready", 128'(ir[g]), 128'(1));
    check("rst_out_valid", 128'(ov[g]), 128'(0));
    check("rst_out_data", od[g], 128'(0));
    check("rst_key_rd_en", 128'(kre[g]), 128'(0));
    check("rst_key_addr", 128'(ka[g]), 128'(0));
    check("rst_busy", 128'(bz[g]), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    iv    = '0;
    ordy  = 2'b11;
    idata = '0;
    kd    = '0;
`ifdef AES_INV_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    expand(0, KEY128, 4, 10);
    expand(1, KEY256, 8, 14);
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain AES-128 block
    send(0, CT128, PT);
    wait_idle(0);

    // in_valid pulses while busy must be ignored
    send(0, CT128, PT);
    repeat (2) @(posedge clk);
    #1;
    iv[0] = 1'b1; idata[0] = 128'hdeadbeef_00000000_cafef00d_12345678;
    check("busy_in_ready", 128'(ir[0]), 128'(0));
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0; idata[0] = '0;
    wait_idle(0);

    // Output back-pressure for 5 cycles
    ordy[0] = 1'b0;
    send(0, CT128, PT);
    n = 0;
    while (!ov[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_valid", 128'(ov[0]), 128'(1));
    repeat (5) @(posedge clk);
    #1;
    check("stall_busy", 128'(bz[0]), 128'(1));
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("post_ready_in_ready", 128'(ir[0]), 128'(1));
    check("post_ready_busy", 128'(bz[0]), 128'(0));
    check("post_ready_valid", 128'(ov[0]), 128'(0));

    // AES-256 block
    send(1, CT256, PT);
    wait_idle(1);

    // Reset in the middle of a block
    send(0, CT128, PT);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset(0);
    void'(q0.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_no_valid", 128'(ov[0]), 128'(0));
    send(0, CT128, PT);
    wait_idle(0);

`ifdef AES_INV_CTRL_ABORT_EN
    send(0, CT128, PT);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", 128'(ir[0]), 128'(1));
    check("abort_busy", 128'(bz[0]), 128'(0));
    check("abort_out_valid", 128'(ov[0]), 128'(0));
    check("abort_out_data", od[0], 128'(0));
    check("abort_key_rd_en", 128'(kre[0]), 128'(0));
    void'(q0.pop_back());
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    send(0, CT128, PT);
    abort = 1'b0;
    wait_idle(0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(q0.size() + q1.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
